// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants (width, taps, default seed, warm-up length) and FSM state type
package lfsr_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic [7:0] TAP_MASK = 8'hB8;
  localparam logic [7:0] SEED_DEFAULT = 8'h01;
  localparam int WARMUP_CYCLES = 8;
  localparam int CNT_W = $clog2(WARMUP_CYCLES);
  typedef enum logic {WARMUP, RUN} state_t;
endpackage

// File: rtl/lfsr_rng_arb_core.sv
// lfsr_core: Fibonacci LFSR (clk, reset, step_en, load_en, load_val -> q); a zero seed is replaced by SEED_DEFAULT
import lfsr_pkg::*;
module lfsr_core #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;
  logic             w_fb;
  assign w_fb = ^(r_q & WIDTH'(TAP_MASK));
  always_ff @(posedge clk) begin
    if (reset) r_q <= WIDTH'(SEED_DEFAULT);
    else if (load_en) r_q <= (load_val == '0) ? WIDTH'(SEED_DEFAULT) : load_val;
    else if (step_en) r_q <= {r_q[WIDTH-2:0], w_fb};
  end
  assign q = r_q;
endmodule

// File: rtl/lfsr_rng_arb.sv
// lfsr_rng_arb: round-robin LFSR word dispenser (clk, reset, req, seed_load, seed -> gnt, rnd_data, rnd_valid, ready)
import lfsr_pkg::*;
module lfsr_rng_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             ready
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_ptr, w_win;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_data, w_q;
  logic             r_valid, w_any, w_grant, w_step;
  assign w_step = (r_state == WARMUP) || w_grant;
  lfsr_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .step_en  (w_step),
    .load_en  (seed_load),
    .load_val (seed),
    .q        (w_q)
  );
  // scan offsets high to low so the smallest offset from r_ptr wins last
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_win = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end
  assign w_grant = (r_state == RUN) && !seed_load && w_any;
  always_comb begin
    w_state_nxt = seed_load ? WARMUP
                : (r_state == WARMUP && r_cnt == CNT_W'(WARMUP_CYCLES - 1)) ? RUN
                : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= WARMUP;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_cnt   <= (seed_load || r_state == RUN) ? '0 : r_cnt + 1'b1;
      r_gnt   <= w_grant ? NREQ'(1) << w_win : '0;
      r_valid <= w_grant;
      if (w_grant) begin
        r_data <= w_q;
        r_ptr  <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end
  assign gnt       = r_gnt;
  assign rnd_data  = r_data;
  assign rnd_valid = r_valid;
  assign ready     = (r_state == RUN);
endmodule

// File: tb/tb_lfsr_rng_arb.sv
// tb_lfsr_rng_arb: directed and random stimulus checked against a sequence-index reference model
module tb_lfsr_rng_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid, ready;
  always #5 clk = ~clk;
  lfsr_rng_arb #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .seed_load (seed_load),
    .seed      (seed),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .ready     (ready)
  );
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] seq [255];
  int pos, warm, ptr;
  bit run;
  logic [3:0] e_gnt;
  logic [7:0] e_data;
  bit e_valid;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int find(input logic [7:0] v);
    for (int i = 0; i < 255; i++) if (seq[i] == v) return i;
    return 0;
  endfunction
  task automatic cycle(input bit r, input bit sl, input logic [7:0] sd, input logic [3:0] rq);
    @(negedge clk);
    reset = r;
    seed_load = sl;
    seed = sd;
    req = rq;
    @(posedge clk);
    e_gnt = '0;
    e_valid = 1'b0;
    if (r) begin
      pos = 0; run = 0; warm = 0; ptr = 0; e_data = '0;
    end else if (sl) begin
      pos = find(sd == 0 ? 8'h01 : sd); run = 0; warm = 0;
    end else if (!run) begin
      pos = (pos + 1) % 255;
      run = (warm == 7);
      warm++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (ptr + k) % 4;
        if (rq[idx]) begin
          e_gnt = 4'(1 << idx);
          e_valid = 1'b1;
          e_data = seq[pos];
          pos = (pos + 1) % 255;
          ptr = (idx + 1) % 4;
          break;
        end
      end
    end
    #1;
    chk("m_gnt", gnt, e_gnt);
    chk("m_data", rnd_data, e_data);
    chk("m_valid", rnd_valid, e_valid);
    chk("m_ready", ready, run);
  endtask
  logic [3:0] rr_exp [5];
  logic [3:0] alt_exp [3];
  initial begin
    seq[0] = 8'h01;
    for (int i = 1; i < 255; i++) seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    alt_exp = '{4'b1000, 4'b0010, 4'b1000};
    cycle(1, 1, 8'h77, 4'b1111);
    chk("rst_ready", ready, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_data", rnd_data, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 4'b0001);
      chk("warm_ready", ready, i == 8);
      chk("warm_gnt", gnt, 0);
    end
    cycle(0, 0, 0, 4'b0001);
    chk("first_gnt", gnt, 4'b0001);
    chk("word0", rnd_data, 8'h1C);
    cycle(0, 0, 0, 4'b0001);
    chk("word1", rnd_data, 8'h38);
    cycle(0, 0, 0, 4'b0001);
    chk("word2", rnd_data, 8'h71);
    cycle(0, 0, 0, 4'b1000);
    chk("to_ptr0", gnt, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 4'b1111);
      chk("rr_all", gnt, rr_exp[i]);
    end
    cycle(0, 0, 0, 4'b0010);
    chk("to_ptr2", gnt, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'b1010);
      chk("rr_1010", gnt, alt_exp[i]);
    end
    cycle(0, 1, 8'h00, 4'b1111);
    chk("seed_gnt", gnt, 0);
    chk("seed_ready", ready, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 4'b1111);
      chk("reseed_gnt", gnt, 0);
      chk("reseed_ready", ready, i == 8);
    end
    cycle(0, 0, 0, 4'b1111);
    chk("reseed_word", rnd_data, 8'h1C);
    chk("reseed_ptr", gnt, 4'b0001);
    cycle(0, 1, 8'h5A, 4'b1111);
    repeat (5) cycle(0, 0, 0, 4'b1111);
    cycle(0, 1, 8'h33, 4'b1111);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 4'b1111);
      chk("restart_ready", ready, i == 8);
    end
    repeat (2) cycle(0, 0, 0, 4'b1111);
    cycle(1, 0, 0, 4'b1111);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_data", rnd_data, 0);
    chk("midrst_valid", rnd_valid, 0);
    chk("midrst_ready", ready, 0);
    repeat (3000) begin
      logic [7:0] s;
      s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0, s, 4'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lfsr_rng_arb.md
LFSR_RNG_ARB -- requirements
Module: lfsr_rng_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the generator.
REQ-002 SHALL have parameter WIDTH, default 8, LFSR and random-word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: `clk` input 1 (rising-edge clock) and `reset` input 1 (synchronous, active-high).
REQ-004 SHALL have `req` input NREQ, one request bit per requester, held high until granted.
REQ-005 SHALL have `seed_load` input 1, a one-cycle strobe that reloads the LFSR.
REQ-006 SHALL have `seed` input WIDTH, the seed value sampled when `seed_load`=1.
REQ-007 SHALL have `gnt` output NREQ, a registered one-hot grant pulse.
REQ-008 SHALL have `rnd_data` output WIDTH, the registered random word for the granted requester.
REQ-009 SHALL have `rnd_valid` output 1, high in exactly the cycles where `gnt` is non-zero.
REQ-010 SHALL have `ready` output 1, high when the FSM is in RUN.

Function
REQ-011 SHALL use a Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1: step = {q[6:0], q[7]^q[5]^q[4]^q[3]}, maximal length 255.
REQ-012 SHALL implement a two-state FSM: WARMUP and RUN.
REQ-013 WARMUP: LFSR steps every cycle and a counter counts 0..WARMUP_CYCLES-1 (WARMUP_CYCLES=8); on the edge where the counter equals 7, the state becomes RUN.
REQ-014 WARMUP: `gnt`=0 and `rnd_valid`=0; requests are ignored but not lost (the requester keeps `req` high).
REQ-015 RUN: LFSR steps only on cycles that issue a grant, so exactly one step per delivered word and no value is reused.
REQ-016 RUN arbitration: round-robin starting at pointer `ptr`; the lowest index i at or after `ptr` (mod NREQ) with req[i]=1 wins.
REQ-017 On a grant to i, the same edge registers gnt=1<<i, rnd_valid=1, rnd_data=pre-step LFSR value, and ptr=(i+1) mod NREQ.
REQ-018 With no requests in RUN: gnt=0, rnd_valid=0, rnd_data holds its last value, and the LFSR and ptr hold.
REQ-019 Latency from req sampled high in RUN with the requester winning to gnt high SHALL be 1 edge; at most one grant per cycle.
REQ-020 `seed_load`=1 in any state SHALL have priority over arbitration: load the LFSR, clear the warm-up counter, enter WARMUP, and register gnt=0 and rnd_valid=0 that edge.
REQ-021 When a seed is loaded, seed==0 SHALL be replaced by SEED_DEFAULT=8'h01 so the LFSR never enters the lock-up state.
REQ-022 `seed_load` during WARMUP SHALL restart warm-up from count 0 with the new seed.
REQ-023 The pointer SHALL NOT change on seed_load, so fairness persists across reseeds.

Reset
REQ-024 When reset=1 at an edge: LFSR=SEED_DEFAULT, state=WARMUP, counter=0, ptr=0, gnt=0, rnd_valid=0, rnd_data=0, ready=0.
REQ-025 Reset SHALL override seed_load and req in the same cycle.
REQ-026 After reset releases, ready rises after the 8th rising edge with reset low; the first grant is possible on the 9th.

Structure
REQ-027 Package lfsr_pkg SHALL hold WIDTH default, tap mask, SEED_DEFAULT, WARMUP_CYCLES and the FSM state enum.
REQ-028 Sub-module lfsr_core (inputs step_en, load_en, load_val; output q) SHALL contain the LFSR register and the zero-seed substitution.
REQ-029 The arbiter, FSM and output registers SHALL reside in lfsr_rng_arb.

Verification
REQ-030 Reset, then req=4'b0001 held -> ready at edge 8; gnt=0001 from edge 9 on; rnd_data sequence 0x1C, 0x38, 0x71 on consecutive cycles.
REQ-031 req=4'b1111 held in RUN from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001; every rnd_data distinct, following the LFSR sequence.
REQ-032 req=4'b1010 with ptr=2 -> gnt=1000, then 0010, then 1000.
REQ-033 seed_load=1 with seed=0 and req=1111 -> gnt=0 for 9 cycles, ready low for 8, LFSR restarts at 0x01, and the first word is 0x1C.
REQ-034 seed_load issued at warm-up count 5 -> warm-up restarts and ready is delayed a further 8 edges; reset asserted mid-grant-stream -> all outputs 0 next edge.
